seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_if.sv | 14 +
 rtl/seq_multiplier.sv | 60 ++++++
 tb/tb_seq_multiplier.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/handshake/result bundle for seq_multiplier.
//   start, signed_mode, x, y : request side (driven by master)
//   busy, done, z            : status and registered product (driven by slave)
interface seq_multiplier_if #(parameter int WIDTH = 4);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     x;
   logic [WIDTH-1:0]     y;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   z;
   modport master(output start, signed_mode, x, y, input busy, done, z);
   modport slave(input start, signed_mode, x, y, output busy, done, z);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, fixed WIDTH-cycle latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seq_multiplier_if (start/signed_mode/x/y in,
//           busy/done/z out)
module seq_multiplier #(parameter int WIDTH = 4) (
   input logic          clk,
   input logic          rst_n,
   seq_multiplier_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t               state, state_next;
   logic [2*WIDTH-1:0]   acc, mcand, sum, z_q;
   logic [WIDTH-1:0]     mplier, mag_x, mag_y;
   logic [CW-1:0]        cnt;
   logic                 neg, last;
   // Signed operands are reduced to magnitudes; the most negative value
   // negates to itself, whose unsigned pattern is exactly its magnitude.
   assign mag_x = (bus.signed_mode && bus.x[WIDTH-1]) ? -bus.x : bus.x;
   assign mag_y = (bus.signed_mode && bus.y[WIDTH-1]) ? -bus.y : bus.y;
   assign sum   = acc + (mplier[0] ? mcand : '0);
   assign last  = cnt == CW'(WIDTH - 1);
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.z    = z_q;
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = bus.start ? RUN : IDLE;
         RUN:     state_next = last ? DONE : RUN;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
         z_q    <= '0;
      end else if (state == IDLE && bus.start) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, mag_x};
         mplier <= mag_y;
         neg    <= bus.signed_mode & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
         cnt    <= '0;
      end else if (state == RUN) begin
         acc    <= sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         // Negating a zero magnitude yields zero, so no separate zero test.
         if (last) z_q <= neg ? -sum : sum;
      end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed, cycle-exact scoreboard bench for seq_multiplier (WIDTH=4).
module tb_seq_multiplier;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   int done_pulses = 0;
   int overlap = 0;
   logic [2*W-1:0] exp_q[$];
   seq_multiplier_if #(.WIDTH(W)) bus();
   seq_multiplier #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.done) done_pulses++;
      if (bus.done && bus.busy) overlap++;
   end
   function automatic logic [2*W-1:0] model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
      int p;
      if (sm) p = $signed(a) * $signed(b);
      else p = a * b;
      return p[2*W-1:0];
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic launch(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.signed_mode = sm;
      bus.x = a;
      bus.y = b;
      exp_q.push_back(model(sm, a, b));
   endtask
   // Called at the negedge where start is presented; returns at the negedge
   // after the result edge. inject pulses start with junk during RUN.
   task automatic complete(input string tag, input bit inject);
      logic [2*W-1:0] prev_z;
      logic [2*W-1:0] exp;
      prev_z = bus.z;
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, " busy@1"}, 32'(bus.busy), 32'd1);
      for (int i = 2; i <= W; i++) begin
         if (inject) begin
            bus.start = (i == 2);
            bus.signed_mode = 1'b1;
            bus.x = 4'h9;
            bus.y = 4'h9;
         end
         @(negedge clk);
         chk({tag, " busy"}, 32'(bus.busy), 32'd1);
         chk({tag, " done early"}, 32'(bus.done), 32'd0);
         chk({tag, " z held"}, 32'(bus.z), 32'(prev_z));
      end
      bus.start = 1'b0;
      @(negedge clk);
      exp = exp_q.pop_front();
      chk({tag, " done"}, 32'(bus.done), 32'd1);
      chk({tag, " busy@done"}, 32'(bus.busy), 32'd0);
      chk({tag, " z"}, 32'(bus.z), 32'(exp));
   endtask
   initial begin
      int d0;
      bus.start = 1'b0;
      bus.signed_mode = 1'b0;
      bus.x = '0;
      bus.y = '0;
      #1;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset z", 32'(bus.z), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(1'b0, 4'hF, 4'hF);
      chk("model 15*15", 32'(exp_q[0]), 32'hE1);
      complete("u 15*15", 1'b0);
      @(negedge clk);
      chk("u 15*15 done drop", 32'(bus.done), 32'd0);
      chk("u 15*15 z hold", 32'(bus.z), 32'hE1);
      @(negedge clk); launch(1'b1, 4'h8, 4'h8); complete("s -8*-8", 1'b0);
      @(negedge clk); launch(1'b1, 4'hD, 4'h5); complete("s -3*5", 1'b0);
      @(negedge clk); launch(1'b1, 4'h0, 4'h9); complete("s 0*-7", 1'b0);
      @(negedge clk); launch(1'b0, 4'h8, 4'h8); complete("u 8*8", 1'b0);
      @(negedge clk); launch(1'b0, 4'hD, 4'h5); complete("u 13*5", 1'b0);
      @(negedge clk); launch(1'b1, 4'h7, 4'h8); complete("s 7*-8", 1'b0);
      @(negedge clk); launch(1'b1, 4'hF, 4'hF); complete("s -1*-1", 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         launch(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         complete("rand", 1'b0);
      end
      // start during RUN and DONE must be ignored
      @(negedge clk);
      d0 = done_pulses;
      launch(1'b0, 4'h3, 4'h5);
      complete("ign run", 1'b1);
      bus.start = 1'b1;
      bus.x = 4'hF;
      bus.y = 4'hF;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ign done busy", 32'(bus.busy), 32'd0);
      chk("ign done done", 32'(bus.done), 32'd0);
      @(negedge clk);
      chk("ign idle busy", 32'(bus.busy), 32'd0);
      chk("ign z", 32'(bus.z), 32'h0F);
      chk("ign one pulse", 32'(done_pulses - d0), 32'd1);
      // asynchronous reset mid-RUN
      @(negedge clk);
      d0 = done_pulses;
      bus.start = 1'b1;
      bus.signed_mode = 1'b0;
      bus.x = 4'hF;
      bus.y = 4'hF;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst z", 32'(bus.z), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst no pulse", 32'(done_pulses - d0), 32'd0);
      launch(1'b0, 4'h3, 4'h4);
      complete("post rst 3*4", 1'b0);
      // back-to-back: second start held through DONE, taken in IDLE
      @(negedge clk);
      d0 = done_pulses;
      launch(1'b0, 4'h7, 4'h9);
      complete("b2b 7*9", 1'b0);
      launch(1'b0, 4'h2, 4'h3);
      @(negedge clk);
      chk("b2b gap busy", 32'(bus.busy), 32'd0);
      chk("b2b gap done", 32'(bus.done), 32'd0);
      complete("b2b 2*3", 1'b0);
      @(negedge clk);
      chk("b2b pulses", 32'(done_pulses - d0), 32'd2);
      chk("busy/done overlap", 32'(overlap), 32'd0);
      chk("queue empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
